// File: rtl/dnn_ctx_normalizer_if.sv
// Stream and configuration bundle for dnn_ctx_normalizer.
// slave = the normalizer itself, master = whoever feeds and drains it.
interface dnn_ctx_normalizer_if #(
  parameter int IBIT = 20,
  parameter int OBIT = 16
);
  // Utterance control
  logic                   clear;
  // Feature input stream
  logic signed [IBIT-1:0] vec_in;
  logic                   dv_in;
  logic                   in_ready;
  // Coefficient load port
  logic                   cfg_we;
  logic                   cfg_sel;
  logic [5:0]             cfg_addr;
  logic signed [IBIT-1:0] cfg_data;
  // Context window output stream
  logic signed [OBIT-1:0] vec_out;
  logic                   dv_out;
  logic                   out_rdy;
  logic                   last_out;
  // Status
  logic                   ovf;

  modport master (
    output clear, vec_in, dv_in, cfg_we, cfg_sel, cfg_addr, cfg_data, out_rdy,
    input  in_ready, vec_out, dv_out, last_out, ovf
  );

  modport slave (
    input  clear, vec_in, dv_in, cfg_we, cfg_sel, cfg_addr, cfg_data, out_rdy,
    output in_ready, vec_out, dv_out, last_out, ovf
  );
endinterface

// File: rtl/dnn_ctx_normalizer.sv
// dnn_ctx_normalizer: per-dimension mean subtraction and scaling of streamed
// feature vectors, stored in a circular buffer of INFRAME frames. After each
// completed frame the whole context window is streamed out, oldest frame
// first, with output backpressure.
//
// Optional feature macro CTX_PAD_EN: when defined, a window is emitted after
// every frame even before INFRAME frames exist; the missing (oldest) frames
// are output as zeros. Undefined: the first window appears only once INFRAME
// frames have been collected since reset/clear.
module dnn_ctx_normalizer #(
  parameter int IBIT    = 20,  // input element width, 14 fractional bits
  parameter int IDIM    = 12,  // elements per frame
  parameter int INFRAME = 5,   // frames in the context window
  parameter int CBIT    = 14,  // scale width, 10 fractional bits
  parameter int OBIT    = 16,  // output width, 10 fractional bits
  parameter int SHIFT   = 14   // product right shift
) (
  input logic                  clk,
  input logic                  reset,
  dnn_ctx_normalizer_if.slave  bus
);

  localparam int DW    = IBIT + 1;                 // difference width
  localparam int PW    = DW + CBIT;                // full product width
  localparam int SW    = PW + 1;                   // product plus rounding bit
  localparam int DEPTH = INFRAME * IDIM;           // buffer entries
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DIMW  = $clog2(IDIM);
  localparam int FCW   = $clog2(INFRAME + 1);

  localparam logic signed [SW-1:0] RND  = SW'(1) <<< (SHIFT - 1);
  localparam logic signed [SW-1:0] OMAX = {{(SW-OBIT+1){1'b0}}, {(OBIT-1){1'b1}}};
  localparam logic signed [SW-1:0] OMIN = {{(SW-OBIT+1){1'b1}}, {(OBIT-1){1'b0}}};

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    EMIT
  } state_t;

  // Coefficients
  logic signed [IBIT-1:0] mean_r  [IDIM];
  logic signed [CBIT-1:0] scale_r [IDIM];
  logic                   cfg_hit;
  logic [DIMW-1:0]        cfg_idx;

  // Context buffer
  logic signed [OBIT-1:0] mem [DEPTH];

  // Control state
  state_t                 state;
  logic [DIMW-1:0]        dim;
  logic [FCW-1:0]         frame_cnt;
  logic [AW-1:0]          wr_base;
  logic [AW-1:0]          next_base;
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          emit_idx;
  logic [1:0]             drain_cnt;
  logic                   emit_go;
  logic                   pad_zero;
  logic                   accept;

  // Registered outputs
  logic                   in_ready_r;
  logic signed [OBIT-1:0] vec_out_r;
  logic                   dv_out_r;
  logic                   last_out_r;
  logic                   ovf_r;

  // Pipeline
  logic                   s1_valid;
  logic signed [DW-1:0]   s1_d;
  logic signed [CBIT-1:0] s1_scale;
  logic [AW-1:0]          s1_addr;
  logic                   s2_valid;
  logic signed [PW-1:0]   s2_p;
  logic [AW-1:0]          s2_addr;
  logic signed [SW-1:0]   rnd_sum;
  logic signed [SW-1:0]   rnd_shr;
  logic signed [OBIT-1:0] r_sat;

  assign accept    = bus.dv_in && in_ready_r;
  assign cfg_hit   = bus.cfg_we && ({1'b0, bus.cfg_addr} < 7'(IDIM));
  assign cfg_idx   = bus.cfg_addr[DIMW-1:0];
  assign next_base = (wr_base == AW'(DEPTH - IDIM)) ? '0 : wr_base + AW'(IDIM);

`ifdef CTX_PAD_EN
  // Number of leading window elements that belong to frames never written.
  logic [AW-1:0] pad_lim;
  assign emit_go  = 1'b1;
  assign pad_zero = (emit_idx < pad_lim);
`else
  assign emit_go  = (frame_cnt == FCW'(INFRAME));
  assign pad_zero = 1'b0;
`endif

  // Coefficient registers: cleared by reset only, they survive clear.
  always_ff @(posedge clk) begin
    // NOTE: every sequential block uses non-blocking assignments so that all
    // registers sample pre-edge values regardless of evaluation order.
    if (reset) begin
      for (int i = 0; i < IDIM; i++) begin
        mean_r[i]  <= '0;
        scale_r[i] <= '0;
      end
    end else if (cfg_hit) begin
      if (bus.cfg_sel) begin
        scale_r[cfg_idx] <= bus.cfg_data[CBIT-1:0];
      end else begin
        mean_r[cfg_idx] <= bus.cfg_data;
      end
    end
  end

  // Pipeline valid bits: flushed by reset and clear so no stale element lands.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
  end

  // Pipeline payload: S1 subtracts the mean and captures the scale so a later
  // cfg write cannot affect an element already in flight; S2 multiplies.
  always_ff @(posedge clk) begin
    s1_d     <= DW'(bus.vec_in) - DW'(mean_r[dim]);
    s1_scale <= scale_r[dim];
    s1_addr  <= wr_base + AW'(dim);
    s2_p     <= PW'(s1_d) * PW'(s1_scale);
    s2_addr  <= s1_addr;
  end

  // S3: round half up, then saturate to the signed output range.
  always_comb begin
    // NOTE: r_sat gets a default before the branches so no path leaves it
    // unassigned, which would otherwise infer a latch.
    r_sat   = rnd_shr[OBIT-1:0];
    rnd_sum = SW'(s2_p) + RND;
    rnd_shr = rnd_sum >>> SHIFT;
    if (rnd_shr > OMAX) begin
      r_sat = {1'b0, {(OBIT-1){1'b1}}};
    end else if (rnd_shr < OMIN) begin
      r_sat = {1'b1, {(OBIT-1){1'b0}}};
    end else begin
      r_sat = rnd_shr[OBIT-1:0];
    end
  end

  // Context buffer write port (S3 result).
  always_ff @(posedge clk) begin
    // NOTE: the buffer is not reset; it is never read before being written,
    // and in the padded build unfilled frames are masked to zero on read.
    if (s2_valid) begin
      mem[s2_addr] <= r_sat;
    end
  end

  // Frame sequencing, window emission and registered outputs.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      state      <= COLLECT;
      in_ready_r <= 1'b1;
      dim        <= '0;
      frame_cnt  <= '0;
      wr_base    <= '0;
      rd_ptr     <= '0;
      emit_idx   <= '0;
      drain_cnt  <= '0;
      vec_out_r  <= '0;
      dv_out_r   <= 1'b0;
      last_out_r <= 1'b0;
      ovf_r      <= 1'b0;
`ifdef CTX_PAD_EN
      pad_lim    <= '0;
`endif
    end else begin
      if (bus.dv_in && !in_ready_r) begin
        ovf_r <= 1'b1;
      end

      case (state)
        COLLECT: begin
          if (accept) begin
            if (dim == DIMW'(IDIM - 1)) begin
              dim        <= '0;
              state      <= DRAIN;
              in_ready_r <= 1'b0;
              drain_cnt  <= '0;
              if (frame_cnt != FCW'(INFRAME)) begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end else begin
              dim <= dim + 1'b1;
            end
          end
        end

        DRAIN: begin
          // Three cycles let the last element of the frame reach the buffer.
          if (drain_cnt == 2'd2) begin
            wr_base <= next_base;
            if (emit_go) begin
              state    <= EMIT;
              rd_ptr   <= next_base;
              emit_idx <= '0;
`ifdef CTX_PAD_EN
              pad_lim  <= AW'((INFRAME - int'(frame_cnt)) * IDIM);
`endif
            end else begin
              state      <= COLLECT;
              in_ready_r <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end

        EMIT: begin
          if (dv_out_r && bus.out_rdy && last_out_r) begin
            dv_out_r   <= 1'b0;
            last_out_r <= 1'b0;
            state      <= COLLECT;
            in_ready_r <= 1'b1;
          end else if (!dv_out_r || bus.out_rdy) begin
            // Output register empty or being consumed: load the next element.
            vec_out_r  <= pad_zero ? '0 : mem[rd_ptr];
            dv_out_r   <= 1'b1;
            last_out_r <= (emit_idx == AW'(DEPTH - 1));
            rd_ptr     <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            emit_idx   <= emit_idx + 1'b1;
          end
        end

        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.vec_out  = vec_out_r;
  assign bus.dv_out   = dv_out_r;
  assign bus.last_out = last_out_r;
  assign bus.ovf      = ovf_r;

endmodule

// File: tb/tb_dnn_ctx_normalizer.sv
// Self-checking bench for dnn_ctx_normalizer. A reference model keeps the
// normalized history of every frame since reset/clear and derives each
// expected context window from it.
module tb_dnn_ctx_normalizer;

  localparam int IBIT    = 20;
  localparam int IDIM    = 12;
  localparam int INFRAME = 5;
  localparam int CBIT    = 14;
  localparam int OBIT    = 16;
  localparam int SHIFT   = 14;
  localparam int DEPTH   = INFRAME * IDIM;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dnn_ctx_normalizer_if #(.IBIT(IBIT), .OBIT(OBIT)) bus ();

  dnn_ctx_normalizer #(
    .IBIT(IBIT), .IDIM(IDIM), .INFRAME(INFRAME),
    .CBIT(CBIT), .OBIT(OBIT), .SHIFT(SHIFT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state
  int mean_m  [IDIM];
  int scale_m [IDIM];
  int hist[$];
  int frames_seen = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Normalized value: floor((x - mean) * scale / 2^SHIFT + 1/2), clamped.
  function automatic int norm(input int x, input int d);
    longint p;
    longint r;
    p = longint'(x - mean_m[d]) * longint'(scale_m[d]);
    r = (p + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic cfg_write(input bit sel, input int addr, input int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_addr = 6'(addr);
    bus.cfg_data = IBIT'(data);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    if (sel) scale_m[addr] = data;
    else     mean_m[addr]  = data;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    hist.delete();
    frames_seen = 0;
  endtask

  task automatic send_frame(input int vals[IDIM]);
    bit ok = 1'b1;
    for (int i = 0; i < IDIM; i++) begin
      int guard = 0;
      bus.dv_in = 1'b0;
      while (!bus.in_ready && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 500) ok = 1'b0;
      bus.vec_in = IBIT'(vals[i]);
      bus.dv_in  = 1'b1;
      @(negedge clk);
    end
    bus.dv_in = 1'b0;
    check("frame_accepted", ok, 1);
    for (int i = 0; i < IDIM; i++) hist.push_back(norm(vals[i], i));
    while (hist.size() > DEPTH) void'(hist.pop_front());
    frames_seen++;
  endtask

  // Observes (or expects the absence of) the window that follows a frame.
  // mode: 0 = out_rdy always high, 1 = random out_rdy, 2 = 10-cycle stall
  // after 20 elements. poke drives dv_in during emission. clear_at >= 0
  // aborts the stream with clear after that many transfers.
  task automatic run_window(input int mode, input bit poke, input int clear_at);
    int   got[$];
    int   exp_w[$];
    bit   expect_emit;
    bit   done = 1'b0;
    bit   held = 1'b0;
    int   held_val = 0;
    int   stall = 0;
    int   cyc = 0;
    logic rdy;
`ifdef CTX_PAD_EN
    expect_emit = 1'b1;
`else
    expect_emit = (frames_seen >= INFRAME);
`endif
    if (!expect_emit) begin
      int seen = 0;
      bus.out_rdy = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (bus.dv_out) seen++;
      end
      check("no_emit", seen, 0);
      return;
    end
    for (int i = hist.size(); i < DEPTH; i++) exp_w.push_back(0);
    foreach (hist[i]) exp_w.push_back(hist[i]);

    while (!done && cyc < 3000) begin
      if (clear_at >= 0 && got.size() == clear_at) begin
        bus.out_rdy = 1'b0;
        bus.dv_in   = 1'b0;
        do_clear();
        check("abort_dv_out", bus.dv_out, 0);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_ovf", bus.ovf, 0);
        return;
      end
      if (held) begin
        check("hold_valid", bus.dv_out, 1);
        check("hold_data", bus.vec_out, held_val);
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          if (got.size() == 20 && stall < 10) begin
            rdy = 1'b0;
            stall++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      bus.out_rdy = rdy;
      held     = bus.dv_out && !rdy;
      held_val = int'(bus.vec_out);
      if (bus.dv_out && rdy) begin
        got.push_back(int'(bus.vec_out));
        check("last_flag", bus.last_out, (got.size() == DEPTH) ? 1 : 0);
        if (bus.last_out) done = 1'b1;
      end
      bus.dv_in  = poke && bus.dv_out && !done;
      bus.vec_in = IBIT'($urandom);
      @(negedge clk);
      cyc++;
    end
    bus.dv_in = 1'b0;
    check("window_done", done, 1);
    check("dv_out_after_last", bus.dv_out, 0);
    check("window_len", got.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("win[%0d]", i), (i < got.size()) ? got[i] : 'x, exp_w[i]);
    end
  endtask

  task automatic const_frame(input int v, input int mode, input bit poke);
    int f[IDIM];
    foreach (f[i]) f[i] = v;
    send_frame(f);
    run_window(mode, poke, -1);
  endtask

  initial begin
    int f[IDIM];
    reset        = 1'b1;
    bus.clear    = 1'b0;
    bus.vec_in   = '0;
    bus.dv_in    = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_sel  = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.out_rdy  = 1'b1;
    foreach (mean_m[i]) begin
      mean_m[i]  = 0;
      scale_m[i] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_vec_out", bus.vec_out, 0);
    check("rst_dv_out", bus.dv_out, 0);
    check("rst_last_out", bus.last_out, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // Unity pass: five frames of 1.0 -> window of 1024s after frame 5
    for (int d = 0; d < IDIM; d++) begin
      cfg_write(1'b0, d, 0);
      cfg_write(1'b1, d, 1024);
    end
    repeat (5) const_frame(16384, 0, 1'b0);
    check("ovf_idle", bus.ovf, 0);

    // Ordering and circular wrap: frame n = n*16384, windows up to frames 3..7
    do_clear();
    for (int n = 1; n <= 5; n++) const_frame(n * 16384, 0, 1'b0);
    const_frame(6 * 16384, 2, 1'b1);           // stall mid-window, poke dv_in
    check("ovf_sticky", bus.ovf, 1);
    const_frame(7 * 16384, 1, 1'b0);

    // Rounding and saturation on dims 0..4
    do_clear();
    cfg_write(1'b0, 0, -524288);
    cfg_write(1'b1, 0, 8191);
    cfg_write(1'b0, 1, 524287);
    cfg_write(1'b1, 1, 8191);
    for (int k = 0; k < 5; k++) begin
      f[0] = 524287;
      f[1] = -524288;
      f[2] = 8;
      f[3] = -8;
      f[4] = -9;
      for (int i = 5; i < IDIM; i++) f[i] = int'($urandom_range(0, 1048575)) - 524288;
      send_frame(f);
      run_window(0, 1'b0, -1);
    end

    // Random coefficients and data with random backpressure
    do_clear();
    for (int d = 0; d < IDIM; d++) begin
      cfg_write(1'b0, d, int'($urandom_range(0, 4000)) - 2000);
      cfg_write(1'b1, d, int'($urandom_range(0, 16383)) - 8192);
    end
    for (int k = 0; k < 6; k++) begin
      foreach (f[i]) f[i] = int'($urandom_range(0, 1048575)) - 524288;
      send_frame(f);
      run_window(1, 1'b0, -1);
    end

    // Clear mid-window, then refill with coefficients retained
    foreach (f[i]) f[i] = int'($urandom_range(0, 65535)) - 32768;
    send_frame(f);
    run_window(0, 1'b0, 25);
    for (int k = 0; k < 5; k++) begin
      foreach (f[i]) f[i] = int'($urandom_range(0, 65535)) - 32768;
      send_frame(f);
      run_window(0, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time limit so a stuck design cannot hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit (%0d/%0d passed)",
             n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
